rob_alloc_ctrl: RTL



---
 rtl/rob_alloc_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl
// ---------------------------------------------------------------------------
// Dual-slot ROB allocation and retirement controller. Owns the ROB ring
// pointers (head, tail, count), hands out ROB ids to dispatching
// instructions, drives the rename table push/pop ports and sequences
// branch-mispredict recovery (RUN -> FLUSH -> RECOVER -> RUN).
//
// Build option:
//   ROB_CTRL_DUAL_RETIRE_EN  defined   : up to two retirements per cycle
//                            undefined : single retirement per cycle, the
//                                        slot1 retire/pop outputs are tied 0
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   disp_vld/wr/reg 0/1             dispatch slots (slot0 is older)
//   disp_rdy0/1, alloc_rob0/1       slot accepted, ROB id assigned
//   push0/1, push_reg/rob_addr0/1   rename table push (new mapping)
//   rob_done                        per-entry completion bits by ROB id
//   pop0/1, pop_reg/rob_addr0/1     rename table pop (retired mapping)
//   retire0/1                       entry retired this cycle
//   flush, flush_rob_addr           mispredict request, branch ROB id
//   flush_out, flush_iq_index       forwarded flush, branch age from head
//   oldest0, count, full, empty     ring status
// ---------------------------------------------------------------------------
module rob_alloc_ctrl #(
   parameter int ROB_DEPTH = 8,
   parameter int ROB_LOG2  = 3,
   parameter int REG_LOG2  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  disp_vld0,
   input  logic                  disp_vld1,
   input  logic                  disp_wr0,
   input  logic                  disp_wr1,
   input  logic [REG_LOG2-1:0]   disp_reg0,
   input  logic [REG_LOG2-1:0]   disp_reg1,
   output logic                  disp_rdy0,
   output logic                  disp_rdy1,
   output logic [ROB_LOG2-1:0]   alloc_rob0,
   output logic [ROB_LOG2-1:0]   alloc_rob1,
   output logic                  push0,
   output logic                  push1,
   output logic [REG_LOG2-1:0]   push_reg_addr0,
   output logic [REG_LOG2-1:0]   push_reg_addr1,
   output logic [ROB_LOG2-1:0]   push_rob_addr0,
   output logic [ROB_LOG2-1:0]   push_rob_addr1,
   input  logic [ROB_DEPTH-1:0]  rob_done,
   output logic                  pop0,
   output logic                  pop1,
   output logic [REG_LOG2-1:0]   pop_reg_addr0,
   output logic [REG_LOG2-1:0]   pop_reg_addr1,
   output logic [ROB_LOG2-1:0]   pop_rob_addr0,
   output logic [ROB_LOG2-1:0]   pop_rob_addr1,
   output logic                  retire0,
   output logic                  retire1,
   input  logic                  flush,
   input  logic [ROB_LOG2-1:0]   flush_rob_addr,
   output logic                  flush_out,
   output logic [ROB_LOG2-1:0]   flush_iq_index,
   output logic [ROB_LOG2-1:0]   oldest0,
   output logic [ROB_LOG2:0]     count,
   output logic                  full,
   output logic                  empty
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_RECOVER
   } state_t;

   localparam logic [ROB_LOG2-1:0] PTR_ONE      = ROB_LOG2'(1);
   localparam logic [ROB_LOG2:0]   CNT_ONE      = (ROB_LOG2+1)'(1);
   localparam logic [ROB_LOG2:0]   CNT_DEPTH    = (ROB_LOG2+1)'(ROB_DEPTH);
   localparam logic [ROB_LOG2:0]   CNT_DEPTH_M1 = (ROB_LOG2+1)'(ROB_DEPTH - 1);

   state_t                state_q, state_d;
   logic [ROB_LOG2-1:0]   head_q, head_d;
   logic [ROB_LOG2-1:0]   tail_q, tail_d;
   logic [ROB_LOG2:0]     count_q, count_d;
   logic [ROB_DEPTH-1:0]  wr_q, wr_d;
   logic [REG_LOG2-1:0]   dest_q [ROB_DEPTH];
   logic [REG_LOG2-1:0]   dest_d [ROB_DEPTH];

   logic                  run_open;
   logic                  retire_open;
   logic [ROB_LOG2:0]     accept_cnt;
   logic [ROB_LOG2:0]     retire_cnt;

   // A flush request in RUN steals the whole cycle: neither dispatch nor
   // retire may move the pointers while the new tail/count are loaded.
   // RECOVER reopens retirement one cycle before dispatch resumes.
   assign run_open    = (state_q == ST_RUN) && !flush;
   assign retire_open = run_open || (state_q == ST_RECOVER);

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_DEPTH);
   assign count   = count_q;
   assign oldest0 = head_q;

   // Dispatch side: slot1 can only ride along with slot0 and needs a
   // second free entry.
   assign disp_rdy0 = run_open && disp_vld0 && (count_q < CNT_DEPTH);
   assign disp_rdy1 = disp_rdy0 && disp_vld1 && (count_q < CNT_DEPTH_M1);

   assign alloc_rob0 = tail_q;
   assign alloc_rob1 = tail_q + PTR_ONE;

   assign push0          = disp_rdy0 && disp_wr0;
   assign push1          = disp_rdy1 && disp_wr1;
   assign push_reg_addr0 = disp_reg0;
   assign push_reg_addr1 = disp_reg1;
   assign push_rob_addr0 = alloc_rob0;
   assign push_rob_addr1 = alloc_rob1;

   // Retire side, oldest entry first.
   assign retire0       = retire_open && !empty && rob_done[head_q];
   assign pop0          = retire0 && wr_q[head_q];
   assign pop_reg_addr0 = dest_q[head_q];
   assign pop_rob_addr0 = head_q;

`ifdef ROB_CTRL_DUAL_RETIRE_EN
   logic [ROB_LOG2-1:0] head_p1;

   assign head_p1       = head_q + PTR_ONE;
   assign retire1       = retire0 && (count_q >= (CNT_ONE + CNT_ONE)) && rob_done[head_p1];
   assign pop1          = retire1 && wr_q[head_p1];
   assign pop_reg_addr1 = dest_q[head_p1];
   assign pop_rob_addr1 = head_p1;
`else
   assign retire1       = 1'b0;
   assign pop1          = 1'b0;
   assign pop_reg_addr1 = '0;
   assign pop_rob_addr1 = '0;
`endif

   // Flush is only honoured in RUN; the index is the branch's distance from
   // head, which is also how many older entries survive (minus one).
   assign flush_out      = (state_q == ST_RUN) && flush;
   assign flush_iq_index = flush_out ? (flush_rob_addr - head_q) : '0;

   assign accept_cnt = {{ROB_LOG2{1'b0}}, disp_rdy0} + {{ROB_LOG2{1'b0}}, disp_rdy1};
   assign retire_cnt = {{ROB_LOG2{1'b0}}, retire0} + {{ROB_LOG2{1'b0}}, retire1};

   // Next-state logic. Normal operation advances tail by accepted slots and
   // head by retired slots; the per-entry wr/dest records are captured at
   // allocation so retirement can pop the right mapping later. A flush
   // rewinds tail to just past the branch and resizes count accordingly;
   // entries beyond it keep stale wr/dest data that is overwritten on reuse.
   always_comb begin
      state_d = state_q;
      head_d  = head_q + retire_cnt[ROB_LOG2-1:0];
      tail_d  = tail_q + accept_cnt[ROB_LOG2-1:0];
      count_d = count_q + accept_cnt - retire_cnt;
      wr_d    = wr_q;
      dest_d  = dest_q;

      if (disp_rdy0) begin
         wr_d[alloc_rob0]   = disp_wr0;
         dest_d[alloc_rob0] = disp_reg0;
      end
      if (disp_rdy1) begin
         wr_d[alloc_rob1]   = disp_wr1;
         dest_d[alloc_rob1] = disp_reg1;
      end

      case (state_q)
         ST_RUN: begin
            if (flush) begin
               tail_d  = flush_rob_addr + PTR_ONE;
               count_d = {1'b0, flush_iq_index} + CNT_ONE;
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH:   state_d = ST_RECOVER;
         ST_RECOVER: state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   // State registers with synchronous reset; reset wins over any flush in
   // progress and empties the ring.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wr_q    <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            dest_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         dest_q  <= dest_d;
      end
   end

endmodule
